// File: rtl/second_row_enemy_ctrl.sv
// Sequential controller for the second-row enemy: owns alive state, position and
// movement phase, and commits the move stage's next position on each move tick.
module second_row_enemy_ctrl #(
    parameter logic [18:0] NONE              = {19{1'b1}},
    parameter logic [8:0]  VERTICAL_POSITION = 9'd108,
    parameter logic [9:0]  START_X           = 10'd100,
    parameter logic [19:0] MOVE_DIV          = 20'd833333,
    parameter logic [7:0]  STEPS_PER_PHASE   = 8'd64
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_Start,
    input  logic        i_Hit,
    input  logic [18:0] i_NextPosition,
    output logic        o_EnemyState,
    output logic [18:0] o_EnemyPosition,
    output logic [1:0]  o_PhaseState,
    output logic        o_MoveTick,
    output logic        o_Destroyed
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACTIVE = 2'd1;
    localparam logic [1:0] DEAD   = 2'd2;

    logic [1:0]  state;
    logic [19:0] divCnt;
    logic [7:0]  stepCnt;
    logic        divWrap;
    logic        stepWrap;
    logic        nextValid;

    assign divWrap   = (divCnt == MOVE_DIV - 20'd1);
    assign stepWrap  = (stepCnt == STEPS_PER_PHASE - 8'd1);
    assign nextValid = (i_NextPosition != NONE);

    // Hit takes priority over a tick on the same edge; a NONE result from the
    // move stage suppresses the commit but the counters keep running.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state           <= IDLE;
            divCnt          <= 20'd0;
            stepCnt         <= 8'd0;
            o_EnemyState    <= 1'b0;
            o_EnemyPosition <= NONE;
            o_PhaseState    <= 2'b00;
            o_MoveTick      <= 1'b0;
            o_Destroyed     <= 1'b0;
        end else begin
            o_MoveTick  <= 1'b0;
            o_Destroyed <= 1'b0;
            case (state)
                ACTIVE: begin
                    if (i_Hit) begin
                        state           <= DEAD;
                        divCnt          <= 20'd0;
                        stepCnt         <= 8'd0;
                        o_EnemyState    <= 1'b0;
                        o_EnemyPosition <= NONE;
                        o_PhaseState    <= 2'b00;
                        o_Destroyed     <= 1'b1;
                    end else if (divWrap) begin
                        divCnt     <= 20'd0;
                        o_MoveTick <= 1'b1;
                        if (nextValid) begin
                            o_EnemyPosition <= i_NextPosition;
                        end
                        if (stepWrap) begin
                            stepCnt      <= 8'd0;
                            o_PhaseState <= o_PhaseState + 2'd1;
                        end else begin
                            stepCnt <= stepCnt + 8'd1;
                        end
                    end else begin
                        divCnt <= divCnt + 20'd1;
                    end
                end
                IDLE, DEAD: begin
                    if (i_Start) begin
                        state           <= ACTIVE;
                        divCnt          <= 20'd0;
                        stepCnt         <= 8'd0;
                        o_EnemyState    <= 1'b1;
                        o_EnemyPosition <= {START_X, VERTICAL_POSITION};
                        o_PhaseState    <= 2'b00;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_second_row_enemy_ctrl.sv
// Scoreboard bench for second_row_enemy_ctrl with a behavioural move stage attached
// (MOVE_DIV=4, STEPS_PER_PHASE=3).
module tb_second_row_enemy_ctrl;

    localparam logic [18:0] NONE  = {19{1'b1}};
    localparam int          STEPS = 3;

    typedef struct packed {
        logic [9:0] x;
        logic [1:0] phase;
    } tickExp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        hit = 1'b0;
    logic        forceNone = 1'b0;
    logic [18:0] nextPosition;
    logic        enemyState;
    logic [18:0] enemyPosition;
    logic [1:0]  phaseState;
    logic        moveTick;
    logic        destroyed;

    int checks = 0;
    int failures = 0;

    tickExp_t   expQ[$];
    logic [9:0] modelX;
    logic [1:0] modelPhase;
    int         modelStep;

    second_row_enemy_ctrl #(
        .NONE(NONE),
        .VERTICAL_POSITION(9'd108),
        .START_X(10'd100),
        .MOVE_DIV(20'd4),
        .STEPS_PER_PHASE(8'd3)
    ) dut (
        .i_Clk(clk),
        .i_Rst(rst),
        .i_Start(start),
        .i_Hit(hit),
        .i_NextPosition(nextPosition),
        .o_EnemyState(enemyState),
        .o_EnemyPosition(enemyPosition),
        .o_PhaseState(phaseState),
        .o_MoveTick(moveTick),
        .o_Destroyed(destroyed)
    );

    always #5 clk = ~clk;

    // Move stage: phases 00/11 step right, 01/10 step left; Y is carried through.
    always_comb begin
        nextPosition = enemyPosition;
        if (forceNone) begin
            nextPosition = NONE;
        end else if (phaseState == 2'b00 || phaseState == 2'b11) begin
            nextPosition = {enemyPosition[18:9] + 10'd1, enemyPosition[8:0]};
        end else begin
            nextPosition = {enemyPosition[18:9] - 10'd1, enemyPosition[8:0]};
        end
    end

    task automatic modelSpawn();
        modelX     = 10'd100;
        modelPhase = 2'b00;
        modelStep  = 0;
    endtask

    task automatic pushTick(input bit skip);
        tickExp_t e;
        if (!skip) begin
            modelX = (modelPhase == 2'b00 || modelPhase == 2'b11) ? modelX + 10'd1 : modelX - 10'd1;
        end
        if (modelStep == STEPS - 1) begin
            modelStep  = 0;
            modelPhase = modelPhase + 2'd1;
        end else begin
            modelStep = modelStep + 1;
        end
        e.x     = modelX;
        e.phase = modelPhase;
        expQ.push_back(e);
    endtask

    task automatic pulseStart();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        checks++;
        if (enemyState !== 1'b0 || enemyPosition !== NONE || phaseState !== 2'b00 ||
            moveTick !== 1'b0 || destroyed !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_values: state=%b pos=%h phase=%b tick=%b destr=%b required 0 %h 00 0 0",
                     enemyState, enemyPosition, phaseState, moveTick, destroyed, NONE);
        end
        @(posedge clk); #1 rst = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (enemyState !== 1'b0 || moveTick !== 1'b0) begin
            failures++;
            $display("[TB] FAIL idle_stays: state=%b tick=%b required 0 0", enemyState, moveTick);
        end
    endtask

    task automatic test_spawn();
        tickExp_t e;
        int cyc;
        pulseStart();
        modelSpawn();
        checks++;
        if (enemyState !== 1'b1 || enemyPosition !== {10'd100, 9'd108} || phaseState !== 2'b00 || moveTick !== 1'b0) begin
            failures++;
            $display("[TB] FAIL spawn: state=%b pos=%h phase=%b tick=%b required 1 %h 00 0",
                     enemyState, enemyPosition, phaseState, moveTick, {10'd100, 9'd108});
        end
        for (int k = 0; k < 3; k++) pushTick(1'b0);
        for (int k = 0; k < 3; k++) begin
            cyc = 0;
            do begin @(negedge clk); cyc++; end while (!moveTick && cyc < 20);
            e = expQ.pop_front();
            checks++;
            if (!moveTick || cyc != 4) begin
                failures++;
                $display("[TB] FAIL spawn_tick_period: tick=%b after %0d clocks required 1 after 4", moveTick, cyc);
            end
            checks++;
            if (enemyPosition !== {e.x, 9'd108} || phaseState !== e.phase) begin
                failures++;
                $display("[TB] FAIL spawn_tick_pos: x=%0d y=%0d phase=%b required x=%0d y=108 phase=%b",
                         enemyPosition[18:9], enemyPosition[8:0], phaseState, e.x, e.phase);
            end
        end
    endtask

    task automatic test_full_cycle();
        tickExp_t e;
        int cyc;
        for (int k = 0; k < 9; k++) pushTick(1'b0);
        for (int k = 0; k < 9; k++) begin
            cyc = 0;
            do begin @(negedge clk); cyc++; end while (!moveTick && cyc < 20);
            e = expQ.pop_front();
            checks++;
            if (!moveTick || cyc != 4) begin
                failures++;
                $display("[TB] FAIL cycle_tick_period: tick=%b after %0d clocks required 1 after 4", moveTick, cyc);
            end
            checks++;
            if (enemyPosition !== {e.x, 9'd108} || phaseState !== e.phase) begin
                failures++;
                $display("[TB] FAIL cycle_tick_pos: x=%0d phase=%b required x=%0d phase=%b",
                         enemyPosition[18:9], phaseState, e.x, e.phase);
            end
        end
        checks++;
        if (enemyPosition[18:9] !== 10'd100 || phaseState !== 2'b00) begin
            failures++;
            $display("[TB] FAIL cycle_net_drift: x=%0d phase=%b required x=100 phase=00",
                     enemyPosition[18:9], phaseState);
        end
    endtask

    task automatic test_hit_on_tick();
        repeat (3) @(posedge clk);
        #1 hit = 1'b1;
        @(posedge clk); #1 hit = 1'b0;
        @(negedge clk);
        checks++;
        if (destroyed !== 1'b1 || moveTick !== 1'b0 || enemyState !== 1'b0 ||
            enemyPosition !== NONE || phaseState !== 2'b00) begin
            failures++;
            $display("[TB] FAIL hit_on_tick: destr=%b tick=%b state=%b pos=%h phase=%b required 1 0 0 %h 00",
                     destroyed, moveTick, enemyState, enemyPosition, phaseState, NONE);
        end
        @(negedge clk);
        checks++;
        if (destroyed !== 1'b0) begin
            failures++;
            $display("[TB] FAIL destroyed_pulse_width: destr=%b required 0", destroyed);
        end
    endtask

    task automatic test_hit_in_dead();
        tickExp_t e;
        int cyc;
        @(posedge clk); #1 hit = 1'b1;
        @(posedge clk); #1 hit = 1'b0;
        @(negedge clk);
        checks++;
        if (destroyed !== 1'b0 || enemyState !== 1'b0 || enemyPosition !== NONE) begin
            failures++;
            $display("[TB] FAIL hit_in_dead: destr=%b state=%b pos=%h required 0 0 %h",
                     destroyed, enemyState, enemyPosition, NONE);
        end
        pulseStart();
        modelSpawn();
        checks++;
        if (enemyState !== 1'b1 || enemyPosition !== {10'd100, 9'd108} || phaseState !== 2'b00) begin
            failures++;
            $display("[TB] FAIL respawn: state=%b pos=%h phase=%b required 1 %h 00",
                     enemyState, enemyPosition, phaseState, {10'd100, 9'd108});
        end
        pushTick(1'b0);
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!moveTick && cyc < 20);
        e = expQ.pop_front();
        checks++;
        if (!moveTick || cyc != 4 || enemyPosition !== {e.x, 9'd108}) begin
            failures++;
            $display("[TB] FAIL respawn_first_tick: tick=%b clocks=%0d x=%0d required 1 4 x=%0d",
                     moveTick, cyc, enemyPosition[18:9], e.x);
        end
    endtask

    task automatic test_none_commit();
        tickExp_t e;
        int cyc;
        pushTick(1'b1);
        pushTick(1'b0);
        for (int k = 0; k < 2; k++) begin
            forceNone = (k == 0);
            cyc = 0;
            do begin @(negedge clk); cyc++; end while (!moveTick && cyc < 20);
            e = expQ.pop_front();
            checks++;
            if (!moveTick || enemyPosition !== {e.x, 9'd108} || phaseState !== e.phase) begin
                failures++;
                $display("[TB] FAIL none_commit: tick=%b x=%0d phase=%b required 1 x=%0d phase=%b",
                         moveTick, enemyPosition[18:9], phaseState, e.x, e.phase);
            end
        end
        forceNone = 1'b0;
    endtask

    task automatic test_reset_midrun();
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++;
        if (enemyState !== 1'b0 || enemyPosition !== NONE || phaseState !== 2'b00 ||
            moveTick !== 1'b0 || destroyed !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_midrun: state=%b pos=%h phase=%b tick=%b destr=%b required 0 %h 00 0 0",
                     enemyState, enemyPosition, phaseState, moveTick, destroyed, NONE);
        end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_spawn();
        test_full_cycle();
        test_hit_on_tick();
        test_hit_in_dead();
        test_none_commit();
        test_reset_midrun();
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left required 0", expQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
